// File: rtl/kernel_cra_pkg.sv
// Shared definitions for the kernel CRA responder: register map, status bits, FSM states.
package kernel_cra_pkg;

   // Control/status register word addresses
   localparam int CRA_CTRL   = 0;
   localparam int CRA_STATUS = 1;
   localparam int CRA_IRQ_EN = 2;
   localparam int CRA_CYCLES = 3;

   // Bit positions inside the CTRL/STATUS words
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int CTRL_START_BIT = 0;
   localparam int STATUS_W1C_BIT = 1;
   localparam int IRQ_EN_BIT     = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/cra_be_reg.sv
// DATA_W-wide register with per-byte write enables and a write-inhibit input.
module cra_be_reg #(
   parameter int DATA_W = 64
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                wr_en,
   input  logic                inhibit,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   writedata,
   output logic [DATA_W-1:0]   q
);

   for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_lane
      logic [7:0] lane_q;

      // Each byte lane loads only when its enable is set and the register is not locked
      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            lane_q <= '0;
         end else if (wr_en && !inhibit && byteenable[gi]) begin
            lane_q <= writedata[gi*8 +: 8];
         end
      end

      assign q[gi*8 +: 8] = lane_q;
   end

endmodule

// File: rtl/kernel_cra_slave.sv
// Avalon-MM CRA responder for one kernel: argument registers, start/busy/done
// tracking, run-cycle counter and completion interrupt.
module kernel_cra_slave
   import kernel_cra_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 64,
   parameter int ARG_BASE = 5,
   parameter int NUM_ARGS = 10,
   parameter int CNT_W    = 32
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       avs_cra_read,
   input  logic                       avs_cra_write,
   input  logic [ADDR_W-1:0]          avs_cra_address,
   input  logic [DATA_W-1:0]          avs_cra_writedata,
   input  logic [DATA_W/8-1:0]        avs_cra_byteenable,
   output logic [DATA_W-1:0]          avs_cra_readdata,
   output logic                       avs_cra_readdatavalid,
   output logic                       kernel_start,
   input  logic                       kernel_done,
   output logic [NUM_ARGS*DATA_W-1:0] kernel_args,
   output logic                       kernel_irq
);

   localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CRA_CTRL);
   localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(CRA_STATUS);
   localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'(CRA_IRQ_EN);
   localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(CRA_CYCLES);

   state_t             state;
   logic               done;
   logic               irq_en;
   logic [CNT_W-1:0]   cycles;
   logic [DATA_W-1:0]  arg_q [NUM_ARGS];
   logic [DATA_W-1:0]  rd_mux;
   logic [DATA_W-1:0]  status_word;
   logic               busy;
   logic               start_req;
   logic               w1c_req;

   assign busy = (state == ST_RUN);

   // Control bits only act when the low byte lane is enabled
   assign start_req = avs_cra_write && (avs_cra_address == A_CTRL) &&
                      avs_cra_byteenable[0] && avs_cra_writedata[CTRL_START_BIT];
   assign w1c_req   = avs_cra_write && (avs_cra_address == A_STATUS) &&
                      avs_cra_byteenable[0] && avs_cra_writedata[STATUS_W1C_BIT];

   assign kernel_irq = done & irq_en;

   // Argument registers; locked while the kernel is running so args stay stable
   for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
      localparam logic [ADDR_W-1:0] ARG_ADDR = ADDR_W'(ARG_BASE + gi);

      cra_be_reg #(
         .DATA_W (DATA_W)
      ) u_arg (
         .clock      (clock),
         .resetn     (resetn),
         .wr_en      (avs_cra_write && (avs_cra_address == ARG_ADDR)),
         .inhibit    (busy),
         .byteenable (avs_cra_byteenable),
         .writedata  (avs_cra_writedata),
         .q          (arg_q[gi])
      );

      assign kernel_args[gi*DATA_W +: DATA_W] = arg_q[gi];
   end

   // Interrupt enable bit, qualified by the low byte lane
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         irq_en <= 1'b0;
      end else if (avs_cra_write && (avs_cra_address == A_IRQ_EN) && avs_cra_byteenable[0]) begin
         irq_en <= avs_cra_writedata[IRQ_EN_BIT];
      end
   end

   // Run FSM: start pulse, busy/done flags and saturating run-cycle counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         kernel_start <= 1'b0;
         done         <= 1'b0;
         cycles       <= '0;
      end else begin
         kernel_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  state        <= ST_RUN;
                  kernel_start <= 1'b1;
                  done         <= 1'b0;
                  cycles       <= '0;
               end else if (w1c_req) begin
                  done <= 1'b0;
               end
            end
            ST_RUN: begin
               if (kernel_done) begin
                  // Completion sets DONE even if a W1C lands on the same edge
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else begin
                  if (cycles != '1) begin
                     cycles <= cycles + 1'b1;
                  end
                  if (w1c_req) begin
                     done <= 1'b0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read mux over the pre-write register contents
   always_comb begin
      status_word            = '0;
      status_word[STAT_BUSY] = busy;
      status_word[STAT_DONE] = done;
      rd_mux                 = '0;
      case (avs_cra_address)
         A_CTRL, A_STATUS: rd_mux = status_word;
         A_IRQ_EN:         rd_mux = {{(DATA_W-1){1'b0}}, irq_en};
         A_CYCLES:         rd_mux = {{(DATA_W-CNT_W){1'b0}}, cycles};
         default: begin
            for (int i = 0; i < NUM_ARGS; i++) begin
               if (avs_cra_address == ADDR_W'(ARG_BASE + i)) begin
                  rd_mux = arg_q[i];
               end
            end
         end
      endcase
   end

   // Fixed one-cycle read response; readdata holds between reads
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         avs_cra_readdatavalid <= 1'b0;
         avs_cra_readdata      <= '0;
      end else begin
         avs_cra_readdatavalid <= avs_cra_read;
         if (avs_cra_read) begin
            avs_cra_readdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_kernel_cra_slave.sv
// Directed bench for kernel_cra_slave: register-map vector table plus hand sequences
// for run/done, read timing, byteenable qualification and reset abort.
module tb_kernel_cra_slave;

   localparam int ADDR_W   = 4;
   localparam int DATA_W   = 64;
   localparam int NUM_ARGS = 10;

   logic                       clock;
   logic                       resetn;
   logic                       avs_cra_read;
   logic                       avs_cra_write;
   logic [ADDR_W-1:0]          avs_cra_address;
   logic [DATA_W-1:0]          avs_cra_writedata;
   logic [DATA_W/8-1:0]        avs_cra_byteenable;
   logic [DATA_W-1:0]          avs_cra_readdata;
   logic                       avs_cra_readdatavalid;
   logic                       kernel_start;
   logic                       kernel_done;
   logic [NUM_ARGS*DATA_W-1:0] kernel_args;
   logic                       kernel_irq;

   kernel_cra_slave dut (
      .clock                 (clock),
      .resetn                (resetn),
      .avs_cra_read          (avs_cra_read),
      .avs_cra_write         (avs_cra_write),
      .avs_cra_address       (avs_cra_address),
      .avs_cra_writedata     (avs_cra_writedata),
      .avs_cra_byteenable    (avs_cra_byteenable),
      .avs_cra_readdata      (avs_cra_readdata),
      .avs_cra_readdatavalid (avs_cra_readdatavalid),
      .kernel_start          (kernel_start),
      .kernel_done           (kernel_done),
      .kernel_args           (kernel_args),
      .kernel_irq            (kernel_irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic        is_wr;
      logic [3:0]  addr;
      logic [63:0] data;
      logic [7:0]  be;
      logic [63:0] exp;
      string       name;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic cra_write(input logic [3:0] addr, input logic [63:0] data, input logic [7:0] be);
      @(negedge clock);
      avs_cra_write      = 1'b1;
      avs_cra_address    = addr;
      avs_cra_writedata  = data;
      avs_cra_byteenable = be;
      @(negedge clock);
      avs_cra_write      = 1'b0;
      avs_cra_byteenable = '0;
      $display("wr  addr=0x%h data=0x%h be=0x%h", addr, data, be);
   endtask

   task automatic cra_read(input logic [3:0] addr, output logic [63:0] data);
      @(negedge clock);
      avs_cra_read    = 1'b1;
      avs_cra_address = addr;
      @(negedge clock);
      avs_cra_read = 1'b0;
      check("rd_valid", {63'b0, avs_cra_readdatavalid}, 64'd1);
      data = avs_cra_readdata;
      $display("rd  addr=0x%h data=0x%h", addr, data);
   endtask

   logic [63:0] rd;
   int          cyc_start;

   initial begin
      resetn             = 1'b0;
      avs_cra_read       = 1'b0;
      avs_cra_write      = 1'b0;
      avs_cra_address    = '0;
      avs_cra_writedata  = '0;
      avs_cra_byteenable = '0;
      kernel_done        = 1'b0;

      vecs[0]  = '{1'b1, 4'h5, 64'h000F4240_00000000, 8'hF0, 64'h0, "arg0_hi"};
      vecs[1]  = '{1'b1, 4'h5, 64'h00000000_000F4240, 8'h0F, 64'h0, "arg0_lo"};
      vecs[2]  = '{1'b0, 4'h5, 64'h0, 8'h00, 64'h000F4240_000F4240, "rd_arg0"};
      vecs[3]  = '{1'b1, 4'hC, 64'h00000000_20100000, 8'h0F, 64'h0, "arg7"};
      vecs[4]  = '{1'b0, 4'hC, 64'h0, 8'h00, 64'h00000000_20100000, "rd_arg7"};
      vecs[5]  = '{1'b1, 4'h6, 64'h11112222_33334444, 8'hFF, 64'h0, "arg1"};
      vecs[6]  = '{1'b0, 4'h6, 64'h0, 8'h00, 64'h11112222_33334444, "rd_arg1"};
      vecs[7]  = '{1'b1, 4'h6, 64'hAAAAAAAA_AAAAAAAA, 8'h00, 64'h0, "arg1_be0"};
      vecs[8]  = '{1'b0, 4'h6, 64'h0, 8'h00, 64'h11112222_33334444, "rd_arg1_be0"};
      vecs[9]  = '{1'b1, 4'hE, 64'hDEADBEEF_01234567, 8'hFF, 64'h0, "arg9"};
      vecs[10] = '{1'b0, 4'hE, 64'h0, 8'h00, 64'hDEADBEEF_01234567, "rd_arg9"};
      vecs[11] = '{1'b1, 4'h4, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'h0, "wr_hole4"};
      vecs[12] = '{1'b0, 4'h4, 64'h0, 8'h00, 64'h0, "rd_hole4"};
      vecs[13] = '{1'b1, 4'hF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'h0, "wr_hole15"};
      vecs[14] = '{1'b0, 4'hF, 64'h0, 8'h00, 64'h0, "rd_hole15"};
      vecs[15] = '{1'b0, 4'h3, 64'h0, 8'h00, 64'h0, "rd_cycles0"};
      vecs[16] = '{1'b1, 4'h2, 64'h00000000_00000001, 8'h02, 64'h0, "irq_en_be1"};
      vecs[17] = '{1'b0, 4'h2, 64'h0, 8'h00, 64'h0, "rd_irq_en_be1"};
      vecs[18] = '{1'b1, 4'h2, 64'h00000000_00000001, 8'h01, 64'h0, "irq_en"};
      vecs[19] = '{1'b0, 4'h2, 64'h0, 8'h00, 64'h1, "rd_irq_en"};

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_valid", {63'b0, avs_cra_readdatavalid}, 64'd0);
      check("rst_rdata", avs_cra_readdata, 64'd0);
      check("rst_start", {63'b0, kernel_start}, 64'd0);
      check("rst_irq", {63'b0, kernel_irq}, 64'd0);
      check("rst_args", {63'b0, (kernel_args == '0)}, 64'd1);
      resetn = 1'b1;
      cra_read(4'h0, rd);
      check("rst_ctrl", rd, 64'd0);

      // Register map vectors
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].is_wr) begin
            cra_write(vecs[i].addr, vecs[i].data, vecs[i].be);
         end else begin
            cra_read(vecs[i].addr, rd);
            check(vecs[i].name, rd, vecs[i].exp);
         end
      end
      check("bus_arg7", kernel_args[7*64 +: 64], 64'h00000000_20100000);
      check("bus_arg0", kernel_args[0*64 +: 64], 64'h000F4240_000F4240);

      // Byteenable 0 on CTRL must not start
      cra_write(4'h0, 64'h1, 8'h00);
      check("be0_no_start", {63'b0, kernel_start}, 64'd0);
      cra_read(4'h0, rd);
      check("be0_idle", rd, 64'd0);

      // Start and run
      cra_write(4'h0, 64'h1, 8'h0F);
      cyc_start = cyc;
      check("start_pulse", {63'b0, kernel_start}, 64'd1);
      @(negedge clock);
      check("start_one_cycle", {63'b0, kernel_start}, 64'd0);
      cra_read(4'h0, rd);
      check("run_busy", rd, 64'd1);
      cra_write(4'h6, 64'h55555555_55555555, 8'hFF);
      cra_read(4'h6, rd);
      check("run_arg_locked", rd, 64'h11112222_33334444);
      cra_write(4'h0, 64'h1, 8'hFF);
      check("run_no_restart", {63'b0, kernel_start}, 64'd0);
      while (cyc - cyc_start < 100) @(negedge clock);
      kernel_done = 1'b1;
      @(negedge clock);
      kernel_done = 1'b0;
      check("done_irq", {63'b0, kernel_irq}, 64'd1);
      cra_read(4'h1, rd);
      check("done_status", rd, 64'd2);
      cra_read(4'h3, rd);
      check("cycles_100", rd, 64'd100);
      repeat (5) @(negedge clock);
      cra_read(4'h3, rd);
      check("cycles_frozen", rd, 64'd100);

      // W1C needs byte lane 0
      cra_write(4'h1, 64'h2, 8'h02);
      check("w1c_be1_irq", {63'b0, kernel_irq}, 64'd1);
      cra_write(4'h1, 64'h2, 8'h01);
      check("w1c_irq", {63'b0, kernel_irq}, 64'd0);
      cra_read(4'h1, rd);
      check("w1c_status", rd, 64'd0);

      // kernel_done while idle is ignored
      @(negedge clock);
      kernel_done = 1'b1;
      @(negedge clock);
      kernel_done = 1'b0;
      check("idle_done_irq", {63'b0, kernel_irq}, 64'd0);

      // Done and W1C on the same edge: done wins
      cra_write(4'h0, 64'h1, 8'h01);
      repeat (3) @(negedge clock);
      avs_cra_write      = 1'b1;
      avs_cra_address    = 4'h1;
      avs_cra_writedata  = 64'h2;
      avs_cra_byteenable = 8'h01;
      kernel_done        = 1'b1;
      @(negedge clock);
      avs_cra_write      = 1'b0;
      avs_cra_byteenable = '0;
      kernel_done        = 1'b0;
      $display("wr  addr=0x1 data=0x2 be=0x01 with kernel_done");
      check("coinc_irq", {63'b0, kernel_irq}, 64'd1);
      cra_read(4'h1, rd);
      check("coinc_status", rd, 64'd2);
      cra_read(4'h3, rd);
      check("coinc_cycles", rd, 64'd3);

      // Back-to-back reads 5, E, 4
      @(negedge clock);
      avs_cra_read    = 1'b1;
      avs_cra_address = 4'h5;
      @(negedge clock);
      check("b2b_v0", {63'b0, avs_cra_readdatavalid}, 64'd1);
      check("b2b_d0", avs_cra_readdata, 64'h000F4240_000F4240);
      avs_cra_address = 4'hE;
      @(negedge clock);
      check("b2b_v1", {63'b0, avs_cra_readdatavalid}, 64'd1);
      check("b2b_d1", avs_cra_readdata, 64'hDEADBEEF_01234567);
      avs_cra_address = 4'h4;
      @(negedge clock);
      check("b2b_v2", {63'b0, avs_cra_readdatavalid}, 64'd1);
      check("b2b_d2", avs_cra_readdata, 64'd0);
      avs_cra_read = 1'b0;
      @(negedge clock);
      check("b2b_v3", {63'b0, avs_cra_readdatavalid}, 64'd0);
      $display("rd  back-to-back addr=0x5,0xE,0x4");

      // Read data holds after the response
      cra_read(4'hE, rd);
      repeat (2) @(negedge clock);
      check("rdata_hold", avs_cra_readdata, 64'hDEADBEEF_01234567);

      // Read and write same address same cycle returns old contents
      @(negedge clock);
      avs_cra_read       = 1'b1;
      avs_cra_write      = 1'b1;
      avs_cra_address    = 4'h5;
      avs_cra_writedata  = 64'hCAFEF00D_12345678;
      avs_cra_byteenable = 8'hFF;
      @(negedge clock);
      avs_cra_read       = 1'b0;
      avs_cra_write      = 1'b0;
      avs_cra_byteenable = '0;
      $display("rdwr addr=0x5 data=0x%h", 64'hCAFEF00D_12345678);
      check("rw_old", avs_cra_readdata, 64'h000F4240_000F4240);
      cra_read(4'h5, rd);
      check("rw_new", rd, 64'hCAFEF00D_12345678);

      // Reset mid-run aborts everything
      cra_write(4'h0, 64'h1, 8'h01);
      repeat (4) @(negedge clock);
      resetn = 1'b0;
      #1;
      check("mid_rst_irq", {63'b0, kernel_irq}, 64'd0);
      check("mid_rst_args", {63'b0, (kernel_args == '0)}, 64'd1);
      check("mid_rst_rdata", avs_cra_readdata, 64'd0);
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      kernel_done = 1'b1;
      @(negedge clock);
      kernel_done = 1'b0;
      check("post_rst_start", {63'b0, kernel_start}, 64'd0);
      check("post_rst_irq", {63'b0, kernel_irq}, 64'd0);
      cra_read(4'h0, rd);
      check("post_rst_ctrl", rd, 64'd0);
      cra_read(4'h2, rd);
      check("post_rst_irq_en", rd, 64'd0);
      cra_read(4'h3, rd);
      check("post_rst_cycles", rd, 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
